control_unit: RTL and testbench

Hardwired sequencer that drives every control input of the `system` datapath: ARF, register file, IR, memory, muxes A/B/C and ALU. It fetches a 16-bit instruction as two bytes addressed by PC, decodes opcode and register fields from the IR high byte, and issues the control word for a single execute cycle. It sits beside `system` in the top level and is the only driver of that datapath's control ports.

---
 rtl/cpu_ctrl_pkg.sv | 94 +++++++++
 rtl/control_unit_if.sv | 39 +++
 rtl/control_unit_instr_decoder.sv | 82 ++++++++
 rtl/control_unit.sv | 88 ++++++++
 tb/tb_control_unit.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and encodings for the hardwired control unit of the 8-bit system datapath.
// Holds the state enum, opcode map, mux/funsel codes and the idle control word.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET,
        ST_FETCH_L,
        ST_FETCH_H,
        ST_EXEC,
        ST_HALT
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_AND  = 4'h6;
    localparam logic [3:0] OP_OR   = 4'h7;
    localparam logic [3:0] OP_XOR  = 4'h8;
    localparam logic [3:0] OP_LSL  = 4'h9;
    localparam logic [3:0] OP_LSR  = 4'hA;
    localparam logic [3:0] OP_LDAR = 4'hB;
    localparam logic [3:0] OP_INC  = 4'hC;
    localparam logic [3:0] OP_BRA  = 4'hD;
    localparam logic [3:0] OP_BEQ  = 4'hE;
    localparam logic [3:0] OP_HLT  = 4'hF;

    localparam logic [1:0] MUX_ALU = 2'b00;
    localparam logic [1:0] MUX_MEM = 2'b01;
    localparam logic [1:0] MUX_IRL = 2'b10;
    localparam logic [1:0] MUX_ARF = 2'b11;

    localparam logic [3:0] ALU_PASS_A = 4'b0000;
    localparam logic [3:0] ALU_ADD    = 4'b0100;
    localparam logic [3:0] ALU_SUB    = 4'b0101;
    localparam logic [3:0] ALU_AND    = 4'b0111;
    localparam logic [3:0] ALU_OR     = 4'b1000;
    localparam logic [3:0] ALU_XOR    = 4'b1010;
    localparam logic [3:0] ALU_LSL    = 4'b1011;
    localparam logic [3:0] ALU_LSR    = 4'b1100;

    localparam logic [1:0] FS_CLR  = 2'b00;
    localparam logic [1:0] FS_LOAD = 2'b01;
    localparam logic [1:0] FS_DEC  = 2'b10;
    localparam logic [1:0] FS_INC  = 2'b11;

    localparam logic [3:0] ARF_PC = 4'b0001;
    localparam logic [3:0] ARF_AR = 4'b1000;

    localparam logic [1:0] OUTB_AR = 2'b00;
    localparam logic [1:0] OUTB_PC = 2'b11;

    typedef struct packed {
        logic [1:0] outasel;
        logic [1:0] outbsel;
        logic [1:0] funsel_ir;
        logic [1:0] funsel_arf;
        logic [1:0] funsel_rf;
        logic [3:0] funsel_alu;
        logic [3:0] regsel_rf;
        logic [3:0] regsel_arf;
        logic [3:0] rf_tsel;
        logic [2:0] rf_o1sel;
        logic [2:0] rf_o2sel;
        logic [1:0] muxsel_a;
        logic [1:0] muxsel_b;
        logic       muxsel_c;
        logic       wr_mem;
        logic       cs_mem;
        logic       ir_enable;
        logic       ir_lh;
    } ctrl_word_t;

    // Nothing written, memory deselected, every funsel parked on "hold/load" with no select.
    localparam ctrl_word_t CTRL_IDLE = '{
        outasel: 2'b00, outbsel: 2'b00,
        funsel_ir: FS_LOAD, funsel_arf: FS_LOAD, funsel_rf: FS_LOAD,
        funsel_alu: 4'b0000, regsel_rf: 4'b0000, regsel_arf: 4'b0000,
        rf_tsel: 4'b0000, rf_o1sel: 3'b000, rf_o2sel: 3'b000,
        muxsel_a: 2'b00, muxsel_b: 2'b00, muxsel_c: 1'b0,
        wr_mem: 1'b0, cs_mem: 1'b1, ir_enable: 1'b0, ir_lh: 1'b0
    };

    function automatic logic [3:0] rf_wsel(input logic [1:0] d);
        return 4'b1000 >> d;
    endfunction

    function automatic logic [2:0] rf_rsel(input logic [1:0] d);
        return {1'b1, d};
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control bus between the sequencer and the system datapath.
// Signal names follow the datapath input ports they drive.
interface control_unit_if;
    logic [7:0] ir_high;
    logic [3:0] alu_flags;
    logic [1:0] outasel;
    logic [1:0] outbsel;
    logic [1:0] funsel_IR;
    logic [1:0] funsel_arf;
    logic [1:0] funsel_rf;
    logic [3:0] funsel_alu;
    logic [3:0] regsel_rf;
    logic [3:0] regsel_arf;
    logic [3:0] rf_tsel;
    logic [2:0] rf_o1sel;
    logic [2:0] rf_o2sel;
    logic [1:0] MUXSelA;
    logic [1:0] MUXSelB;
    logic       MUXSelC;
    logic       wrMEM;
    logic       csMEM;
    logic       IR_enable;
    logic       IR_lh;
    logic       halted;

    modport master (
        input  ir_high, alu_flags,
        output outasel, outbsel, funsel_IR, funsel_arf, funsel_rf, funsel_alu,
               regsel_rf, regsel_arf, rf_tsel, rf_o1sel, rf_o2sel,
               MUXSelA, MUXSelB, MUXSelC, wrMEM, csMEM, IR_enable, IR_lh, halted
    );

    modport slave (
        output ir_high, alu_flags,
        input  outasel, outbsel, funsel_IR, funsel_arf, funsel_rf, funsel_alu,
               regsel_rf, regsel_arf, rf_tsel, rf_o1sel, rf_o2sel,
               MUXSelA, MUXSelB, MUXSelC, wrMEM, csMEM, IR_enable, IR_lh, halted
    );
endinterface

// File: rtl/control_unit_instr_decoder.sv
// Combinational map from (opcode, Rd, Rs, z_q) to the control word for the single EXEC cycle.
// Pure decode, no state; fields not touched by an opcode stay at the idle word.
module instr_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [1:0] rd,
    input  logic [1:0] rs,
    input  logic       z_q,
    output ctrl_word_t word
);

    logic [3:0] alu_sel;

    always_comb begin
        alu_sel = ALU_PASS_A;
        case (opcode)
            OP_ADD:  alu_sel = ALU_ADD;
            OP_SUB:  alu_sel = ALU_SUB;
            OP_AND:  alu_sel = ALU_AND;
            OP_OR:   alu_sel = ALU_OR;
            OP_XOR:  alu_sel = ALU_XOR;
            OP_LSL:  alu_sel = ALU_LSL;
            OP_LSR:  alu_sel = ALU_LSR;
            default: alu_sel = ALU_PASS_A;
        endcase
    end

    always_comb begin
        word = CTRL_IDLE;
        case (opcode)
            OP_LDI: begin
                word.regsel_rf = rf_wsel(rd);
                word.muxsel_a  = MUX_IRL;
                word.funsel_rf = FS_LOAD;
            end
            OP_LD: begin
                word.regsel_rf = rf_wsel(rd);
                word.outbsel   = OUTB_AR;
                word.cs_mem    = 1'b0;
                word.muxsel_a  = MUX_MEM;
                word.funsel_rf = FS_LOAD;
            end
            // Store routes Rd through the ALU in pass-A mode onto the memory data bus.
            OP_ST: begin
                word.rf_o1sel   = rf_rsel(rd);
                word.muxsel_c   = 1'b0;
                word.funsel_alu = ALU_PASS_A;
                word.outbsel    = OUTB_AR;
                word.cs_mem     = 1'b0;
                word.wr_mem     = 1'b1;
            end
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_LSL, OP_LSR: begin
                word.regsel_rf  = rf_wsel(rd);
                word.rf_o1sel   = rf_rsel(rd);
                word.rf_o2sel   = (opcode <= OP_XOR) ? rf_rsel(rs) : 3'b000;
                word.muxsel_c   = 1'b0;
                word.muxsel_a   = MUX_ALU;
                word.funsel_alu = alu_sel;
                word.funsel_rf  = FS_LOAD;
            end
            OP_LDAR: begin
                word.muxsel_b   = MUX_IRL;
                word.regsel_arf = ARF_AR;
                word.funsel_arf = FS_LOAD;
            end
            OP_INC: begin
                word.regsel_rf = rf_wsel(rd);
                word.funsel_rf = FS_INC;
            end
            OP_BRA, OP_BEQ: begin
                if (opcode == OP_BRA || z_q) begin
                    word.muxsel_b   = MUX_IRL;
                    word.regsel_arf = ARF_PC;
                    word.funsel_arf = FS_LOAD;
                end
            end
            default: word = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Fetch/execute sequencer: RESET -> FETCH_L -> FETCH_H -> EXEC, HLT parks in HALT until reset.
// Outputs are a combinational decode of state, ir_high and z_q; 3 cycles per instruction.
module control_unit
    import cpu_ctrl_pkg::*;
(
    input  logic           clock,
    input  logic           reset_n,
    control_unit_if.master bus
);

    state_t     state;
    logic       z_q;
    ctrl_word_t exec_word;
    ctrl_word_t word;
    logic [3:0] opcode;
    logic       unused_flags;

    assign opcode       = bus.ir_high[7:4];
    assign unused_flags = ^bus.alu_flags[2:0];

    instr_decoder u_dec (
        .opcode (opcode),
        .rd     (bus.ir_high[3:2]),
        .rs     (bus.ir_high[1:0]),
        .z_q    (z_q),
        .word   (exec_word)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_RESET;
            z_q   <= 1'b0;
        end else begin
            case (state)
                ST_RESET:   state <= ST_FETCH_L;
                ST_FETCH_L: state <= ST_FETCH_H;
                ST_FETCH_H: state <= ST_EXEC;
                ST_EXEC: begin
                    state <= (opcode == OP_HLT) ? ST_HALT : ST_FETCH_L;
                    // Only ALU-writing ops update the zero flag seen by BEQ.
                    if (opcode >= OP_ADD && opcode <= OP_LSR)
                        z_q <= bus.alu_flags[3];
                end
                ST_HALT:    state <= ST_HALT;
                default:    state <= ST_RESET;
            endcase
        end
    end

    always_comb begin
        word = CTRL_IDLE;
        case (state)
            ST_FETCH_L, ST_FETCH_H: begin
                word.outbsel    = OUTB_PC;
                word.cs_mem     = 1'b0;
                word.wr_mem     = 1'b0;
                word.ir_enable  = 1'b1;
                word.funsel_ir  = FS_LOAD;
                word.ir_lh      = (state == ST_FETCH_H);
                word.regsel_arf = ARF_PC;
                word.funsel_arf = FS_INC;
            end
            ST_EXEC: word = exec_word;
            default: word = CTRL_IDLE;
        endcase
    end

    assign bus.outasel    = word.outasel;
    assign bus.outbsel    = word.outbsel;
    assign bus.funsel_IR  = word.funsel_ir;
    assign bus.funsel_arf = word.funsel_arf;
    assign bus.funsel_rf  = word.funsel_rf;
    assign bus.funsel_alu = word.funsel_alu;
    assign bus.regsel_rf  = word.regsel_rf;
    assign bus.regsel_arf = word.regsel_arf;
    assign bus.rf_tsel    = word.rf_tsel;
    assign bus.rf_o1sel   = word.rf_o1sel;
    assign bus.rf_o2sel   = word.rf_o2sel;
    assign bus.MUXSelA    = word.muxsel_a;
    assign bus.MUXSelB    = word.muxsel_b;
    assign bus.MUXSelC    = word.muxsel_c;
    assign bus.wrMEM      = word.wr_mem;
    assign bus.csMEM      = word.cs_mem;
    assign bus.IR_enable  = word.ir_enable;
    assign bus.IR_lh      = word.ir_lh;
    assign bus.halted     = (state == ST_HALT);

endmodule

// File: tb/tb_control_unit.sv
// Randomized bench for control_unit: an instruction-level model predicts the full control word every cycle,
// with hand-computed checks for reset, LDI, SUB/BEQ, LDAR/ST, HLT and a mid-fetch asynchronous reset.
module tb_control_unit;

    logic clock;
    logic reset_n;

    control_unit_if bus ();

    control_unit dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int vectors     = 0;
    int miscompares = 0;

    logic [41:0] dut_vec;
    assign dut_vec = {bus.outasel, bus.outbsel, bus.funsel_IR, bus.funsel_arf, bus.funsel_rf,
                      bus.funsel_alu, bus.regsel_rf, bus.regsel_arf, bus.rf_tsel,
                      bus.rf_o1sel, bus.rf_o2sel, bus.MUXSelA, bus.MUXSelB, bus.MUXSelC,
                      bus.wrMEM, bus.csMEM, bus.IR_enable, bus.IR_lh, bus.halted};

    // Hand-built idle word: funsel_IR/arf/rf = 01, csMEM = 1, everything else 0.
    localparam logic [41:0] IDLE_LIT = {2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 4'b0000, 4'b0000,
                                        4'b0000, 4'b0000, 3'b000, 3'b000, 2'b00, 2'b00,
                                        1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    localparam logic [41:0] HALT_LIT = IDLE_LIT | 42'd1;

    // Model phase: 0 reset, 1 fetch low, 2 fetch high, 3 execute, 4 halted.
    int   phase = 0;
    logic mz    = 1'b0;

    function automatic logic [41:0] expect_word(input int ph, input logic [7:0] ir, input logic zq);
        logic [1:0] oa, ob, fir, farf, frf, ma, mb;
        logic [3:0] falu, rrf, rarf, ts, op;
        logic [2:0] o1, o2;
        logic       mc, wr, cs, ire, lh, h;
        logic [1:0] rd, rs;
        oa = 2'b00; ob = 2'b00; fir = 2'b01; farf = 2'b01; frf = 2'b01;
        falu = 4'b0000; rrf = 4'b0000; rarf = 4'b0000; ts = 4'b0000;
        o1 = 3'b000; o2 = 3'b000; ma = 2'b00; mb = 2'b00;
        mc = 1'b0; wr = 1'b0; cs = 1'b1; ire = 1'b0; lh = 1'b0;
        h  = (ph == 4);
        op = ir[7:4]; rd = ir[3:2]; rs = ir[1:0];
        if (ph == 1 || ph == 2) begin
            ob = 2'b11; cs = 1'b0; ire = 1'b1; lh = (ph == 2);
            rarf = 4'b0001; farf = 2'b11;
        end else if (ph == 3) begin
            if (op inside {4'h1, 4'h2, [4'h4:4'hA], 4'hC}) begin
                rrf = 4'b1000 >> rd;
                frf = (op == 4'hC) ? 2'b11 : 2'b01;
            end
            if (op inside {4'h3, [4'h4:4'hA]}) o1 = {1'b1, rd};
            if (op inside {[4'h4:4'h8]})       o2 = {1'b1, rs};
            case (op)
                4'h4: falu = 4'b0100;
                4'h5: falu = 4'b0101;
                4'h6: falu = 4'b0111;
                4'h7: falu = 4'b1000;
                4'h8: falu = 4'b1010;
                4'h9: falu = 4'b1011;
                4'hA: falu = 4'b1100;
                default: falu = 4'b0000;
            endcase
            if (op == 4'h1) ma = 2'b10;
            if (op == 4'h2) ma = 2'b01;
            if (op == 4'h2 || op == 4'h3) cs = 1'b0;
            wr = (op == 4'h3);
            if (op == 4'hB) begin
                rarf = 4'b1000; farf = 2'b01; mb = 2'b10;
            end
            if (op == 4'hD || (op == 4'hE && zq)) begin
                rarf = 4'b0001; farf = 2'b01; mb = 2'b10;
            end
        end
        return {oa, ob, fir, farf, frf, falu, rrf, rarf, ts, o1, o2, ma, mb, mc, wr, cs, ire, lh, h};
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            phase = 0;
            mz    = 1'b0;
        end else begin
            if (phase == 3 && bus.ir_high[7:4] >= 4'h4 && bus.ir_high[7:4] <= 4'hA)
                mz = bus.alu_flags[3];
            case (phase)
                0: phase = 1;
                1: phase = 2;
                2: phase = 3;
                3: phase = (bus.ir_high[7:4] == 4'hF) ? 4 : 1;
                default: phase = 4;
            endcase
        end
    end

    logic [41:0] want_c;
    always @(negedge clock) begin
        want_c = expect_word(phase, bus.ir_high, mz);
        vectors++;
        if (dut_vec !== want_c) begin
            miscompares++;
            $display("FAIL cycle t=%0t phase=%0d ir=%h: got %h, required %h",
                     $time, phase, bus.ir_high, dut_vec, want_c);
        end
    end

    task automatic lit(input string name, input logic [41:0] got, input logic [41:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    task automatic step(input logic [7:0] ir, input logic [3:0] fl);
        @(posedge clock);
        #1;
        bus.ir_high   = ir;
        bus.alu_flags = fl;
        #1;
    endtask

    task automatic run(input logic [7:0] hi, input logic [3:0] fl);
        step(8'($urandom), 4'($urandom));
        step(8'($urandom), 4'($urandom));
        step(hi, fl);
    endtask

    initial begin
        logic [7:0] b;
        reset_n       = 1'b1;
        bus.ir_high   = 8'h00;
        bus.alu_flags = 4'h0;
        #1 reset_n = 1'b0;

        repeat (3) begin
            step(8'($urandom), 4'($urandom));
            lit("rst_csmem", 42'(bus.csMEM), 42'(1));
            lit("rst_word", dut_vec, IDLE_LIT);
        end
        reset_n = 1'b1;

        step(8'($urandom), 4'($urandom));
        lit("fl_outbsel", 42'(bus.outbsel), 42'(2'b11));
        lit("fl_lh", 42'(bus.IR_lh), 42'(0));
        step(8'($urandom), 4'($urandom));
        lit("fh_lh", 42'(bus.IR_lh), 42'(1));
        step(8'h1C, 4'($urandom));
        lit("ldi_regsel", 42'(bus.regsel_rf), 42'(4'b0001));
        lit("ldi_muxa", 42'(bus.MUXSelA), 42'(2'b10));

        for (int pass = 0; pass < 2; pass++) begin
            run(8'h10, 4'($urandom));
            run(8'h14, 4'($urandom));
            run(8'h51, (pass == 0) ? 4'b1000 : 4'b0111);
            lit("sub_alu", 42'(bus.funsel_alu), 42'(4'b0101));
            lit("sub_o1", 42'(bus.rf_o1sel), 42'(3'b100));
            lit("sub_o2", 42'(bus.rf_o2sel), 42'(3'b101));
            run(8'hE0, 4'($urandom));
            if (pass == 0) begin
                lit("beq_taken_arf", 42'(bus.regsel_arf), 42'(4'b0001));
                lit("beq_taken_muxb", 42'(bus.MUXSelB), 42'(2'b10));
            end else begin
                lit("beq_not_taken", dut_vec, IDLE_LIT);
            end
        end

        run(8'hB0, 4'($urandom));
        lit("ldar_arf", 42'(bus.regsel_arf), 42'(4'b1000));
        run(8'h38, 4'($urandom));
        lit("st_wr", 42'(bus.wrMEM), 42'(1));
        lit("st_cs", 42'(bus.csMEM), 42'(0));
        lit("st_outb", 42'(bus.outbsel), 42'(2'b00));
        lit("st_o1", 42'(bus.rf_o1sel), 42'(3'b110));

        for (int i = 0; i < 150; i++) begin
            b = 8'($urandom);
            if (b[7:4] == 4'hF) b[7:4] = 4'h0;
            run(b, 4'($urandom));
        end

        run(8'h51, 4'b1000);
        step(8'($urandom), 4'($urandom));
        step(8'($urandom), 4'($urandom));
        #1 reset_n = 1'b0;
        #1;
        lit("arst_word", dut_vec, IDLE_LIT);
        lit("arst_ir_en", 42'(bus.IR_enable), 42'(0));
        @(posedge clock);
        #1 reset_n = 1'b1;
        run(8'hE0, 4'($urandom));
        lit("beq_after_rst", dut_vec, IDLE_LIT);

        run(8'hF0, 4'($urandom));
        lit("hlt_exec", dut_vec, IDLE_LIT);
        repeat (20) begin
            step(8'($urandom), 4'($urandom));
            lit("halt_word", dut_vec, HALT_LIT);
        end
        reset_n = 1'b0;
        #1;
        lit("halt_rst", dut_vec, IDLE_LIT);
        step(8'($urandom), 4'($urandom));
        reset_n = 1'b1;
        step(8'($urandom), 4'($urandom));
        lit("post_halt_fl", 42'(bus.outbsel), 42'(2'b11));
        run(8'h2D, 4'($urandom));
        run(8'hC4, 4'($urandom));
        step(8'($urandom), 4'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
